prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 10 +
 rtl/prog_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - load stream handshake bundle between a program source and prog_loader
interface prog_loader_if;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;
   logic        in_ready;

   modport master (output in_valid, in_data, in_last, input in_ready);
   modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program into single-port RAM, checksum-verifies it, then releases the CPU
// and hands it the RAM port.
module prog_loader #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_req,
   prog_loader_if.slave    ld,
   input  logic            cpu_wrEn,
   input  logic [SIZE-1:0] cpu_addr,
   input  logic [15:0]     cpu_din,
   output logic [15:0]     cpu_dout,
   output logic            ram_we,
   output logic [SIZE-1:0] ram_addr,
   output logic [15:0]     ram_din,
   input  logic [15:0]     ram_dout,
   output logic            cpu_rst,
   output logic            done,
   output logic            err,
   output logic [SIZE:0]   word_cnt
);

   typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERR} stateT;

   localparam logic [SIZE-1:0] TOP_ADDR = '1;

   stateT           state, nextState;
   logic [SIZE-1:0] wrPtr;
   logic [SIZE:0]   rdPtr;
   logic [SIZE:0]   wordCnt;
   logic [15:0]     loadSum;
   logic [15:0]     verifySum;
   logic [15:0]     verifyTotal;
   logic            accept;
   logic            lastRead;

   // A restart request wins over a word offered in the same cycle.
   assign accept      = (state == LOAD) && ld.in_valid && !load_req;
   assign lastRead    = (state == VERIFY) && (rdPtr == wordCnt);
   assign verifyTotal = verifySum + ram_dout;

   assign ld.in_ready = (state == LOAD);
   assign done        = (state == RUN);
   assign cpu_rst     = (state != RUN);
   assign err         = (state == ERR);
   assign cpu_dout    = ram_dout;
   assign word_cnt    = wordCnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      case (state)
         IDLE: ;
         LOAD: begin
            ram_we   = accept;
            ram_addr = wrPtr;
            ram_din  = ld.in_data;
            if (accept && ld.in_last)
               nextState = VERIFY;
            else if (accept && wrPtr == TOP_ADDR)
               nextState = ERR;
         end
         VERIFY: begin
            // On the final cycle rdPtr may equal the RAM depth; that extra read is discarded.
            ram_addr = rdPtr[SIZE-1:0];
            if (lastRead)
               nextState = (verifyTotal == loadSum) ? RUN : ERR;
         end
         RUN: begin
            ram_we   = cpu_wrEn;
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
         end
         ERR: ;
         default: nextState = IDLE;
      endcase
      if (load_req)
         nextState = LOAD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr     <= '0;
         wordCnt   <= '0;
         loadSum   <= '0;
         rdPtr     <= '0;
         verifySum <= '0;
      end else if (load_req) begin
         wrPtr     <= '0;
         wordCnt   <= '0;
         loadSum   <= '0;
         rdPtr     <= '0;
         verifySum <= '0;
      end else if (accept) begin
         wrPtr   <= wrPtr + 1'b1;
         wordCnt <= wordCnt + 1'b1;
         loadSum <= loadSum + ld.in_data;
         if (ld.in_last) begin
            rdPtr     <= '0;
            verifySum <= '0;
         end
      end else if (state == VERIFY && !lastRead) begin
         rdPtr <= rdPtr + 1'b1;
         // Read data lags its address by one cycle, so nothing arrives on the first cycle.
         if (rdPtr != '0)
            verifySum <= verifySum + ram_dout;
      end
   end

endmodule
